// File: rtl/imm_pack.sv
// imm_pack: streaming RISC-V immediate encoder with a two-entry output/skid buffer and saturating statistics.
// Optional build macro IMM_PACK_DROP_ERR_EN: error requests are counted but never forwarded.
module imm_pack #(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    // Format codes shared with the core's immediate-extraction path.
    localparam logic [2:0] SEXT_R    = 3'd0;
    localparam logic [2:0] SEXT_I    = 3'd1;
    localparam logic [2:0] SEXT_MOVE = 3'd2;
    localparam logic [2:0] SEXT_S    = 3'd3;
    localparam logic [2:0] SEXT_B    = 3'd4;
    localparam logic [2:0] SEXT_U    = 3'd5;
    localparam logic [2:0] SEXT_J    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_t;

    // Scatter the immediate into the template; err flags values the format cannot hold.
    function automatic enc_t encode(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm);
        enc_t res;
        res.inst = base;
        res.err  = 1'b0;
        case (op)
            SEXT_R: begin
                res.err = (imm != 32'd0);
            end
            SEXT_I: begin
                res.inst[31:20] = imm[11:0];
                res.err         = (imm[31:11] != {21{imm[11]}});
            end
            SEXT_MOVE: begin
                res.inst[24:20] = imm[4:0];
                res.err         = (imm[31:5] != 27'd0);
            end
            SEXT_S: begin
                res.inst[31:25] = imm[11:5];
                res.inst[11:7]  = imm[4:0];
                res.err         = (imm[31:11] != {21{imm[11]}});
            end
            SEXT_B: begin
                res.inst[31]    = imm[12];
                res.inst[7]     = imm[11];
                res.inst[30:25] = imm[10:5];
                res.inst[11:8]  = imm[4:1];
                res.err         = imm[0] | (imm[31:12] != {20{imm[12]}});
            end
            SEXT_U: begin
                res.inst[31:12] = imm[31:12];
                res.err         = (imm[11:0] != 12'd0);
            end
            SEXT_J: begin
                res.inst[31]    = imm[20];
                res.inst[30:21] = imm[10:1];
                res.inst[20]    = imm[11];
                res.inst[19:12] = imm[19:12];
                res.err         = imm[0] | (imm[31:20] != {12{imm[20]}});
            end
            default: begin
                res.err = 1'b1;
            end
        endcase
        return res;
    endfunction

    enc_t enc_s;
    logic accept_s;
    logic push_s;
    logic drain_s;

    logic out_valid_r;
    enc_t out_data_r;
    logic skid_valid_r;
    enc_t skid_data_r;
    logic in_ready_r;

    logic out_valid_n;
    enc_t out_data_n;
    logic skid_valid_n;
    enc_t skid_data_n;

    logic [CNT_W-1:0] cnt_ok_r;
    logic [CNT_W-1:0] cnt_err_r;

    assign enc_s    = encode(in_op, in_base, in_imm);
    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = out_valid_r & out_ready;

`ifdef IMM_PACK_DROP_ERR_EN
    assign push_s = accept_s & ~enc_s.err;
`else
    assign push_s = accept_s;
`endif

    // Next state of the output and skid entries; the skid only fills while the output entry stalls.
    always_comb begin
        out_valid_n  = out_valid_r;
        out_data_n   = out_data_r;
        skid_valid_n = skid_valid_r;
        skid_data_n  = skid_data_r;
        if (drain_s) begin
            if (skid_valid_r) begin
                out_data_n   = skid_data_r;
                skid_valid_n = 1'b0;
            end else if (push_s) begin
                out_data_n = enc_s;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (push_s) begin
            if (out_valid_r) begin
                skid_valid_n = 1'b1;
                skid_data_n  = enc_s;
            end else begin
                out_valid_n = 1'b1;
                out_data_n  = enc_s;
            end
        end else begin
            out_valid_n = out_valid_r;
        end
    end

    // Buffer registers; in_ready is registered as "skid will be empty".
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '{inst: 32'd0, err: 1'b0};
            skid_valid_r <= 1'b0;
            skid_data_r  <= '{inst: 32'd0, err: 1'b0};
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_n;
            out_data_r   <= out_data_n;
            skid_valid_r <= skid_valid_n;
            skid_data_r  <= skid_data_n;
            in_ready_r   <= ~skid_valid_n;
        end
    end

    // Saturating accept statistics, counted even for requests that are dropped.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt_ok_r  <= {CNT_W{1'b0}};
            cnt_err_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (enc_s.err) begin
                if (cnt_err_r != CNT_MAX) begin
                    cnt_err_r <= cnt_err_r + CNT_W'(1);
                end else begin
                    cnt_err_r <= cnt_err_r;
                end
            end else begin
                if (cnt_ok_r != CNT_MAX) begin
                    cnt_ok_r <= cnt_ok_r + CNT_W'(1);
                end else begin
                    cnt_ok_r <= cnt_ok_r;
                end
            end
        end else begin
            cnt_ok_r  <= cnt_ok_r;
            cnt_err_r <= cnt_err_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_inst  = out_data_r.inst;
    assign out_err   = out_data_r.err;
    assign cnt_ok    = cnt_ok_r;
    assign cnt_err   = cnt_err_r;

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack: directed encodings, backpressure, saturation, async reset and a
// randomized stream scored against a queue-based reference model.
module tb_imm_pack;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef IMM_PACK_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    localparam logic [2:0] OP_R = 3'd0, OP_I = 3'd1, OP_MV = 3'd2, OP_S = 3'd3;
    localparam logic [2:0] OP_B = 3'd4, OP_U = 3'd5, OP_J = 3'd6, OP_BAD = 3'd7;

    logic             cpu_clk = 1'b0;
    logic             cpu_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_base;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_err;

    imm_pack #(.CNT_W(CNT_W)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_base  (in_base),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_err  (out_err),
        .cnt_ok   (cnt_ok),
        .cnt_err  (cnt_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   m_ok;
    int   m_err;
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: field placement by masks/shifts, representability by signed range arithmetic.
    function automatic void ref_enc(input logic [2:0] op, input logic [31:0] b, input logic [31:0] imm,
                                    output logic [31:0] r, output logic e);
        int signed si;
        si = imm;
        case (op)
            OP_R:  begin r = b; e = (imm != 32'd0); end
            OP_I:  begin r = (b & 32'h000FFFFF) | ((imm & 32'hFFF) << 20); e = (si < -2048) || (si > 2047); end
            OP_MV: begin r = (b & ~32'h01F00000) | ((imm & 32'h1F) << 20); e = (imm > 32'd31); end
            OP_S:  begin
                r = (b & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = (si < -2048) || (si > 2047);
            end
            OP_B:  begin
                r = (b & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
                e = (si % 2 != 0) || (si < -4096) || (si > 4095);
            end
            OP_U:  begin r = (b & 32'h00000FFF) | (imm & 32'hFFFFF000); e = ((imm & 32'hFFF) != 32'd0); end
            OP_J:  begin
                r = (b & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000);
                e = (si % 2 != 0) || (si < -(1 << 20)) || (si > (1 << 20) - 1);
            end
            default: begin r = b; e = 1'b1; end
        endcase
    endfunction

    // One clock: predict accept/drain from the current pins, advance the model, then check after the edge.
    task automatic cycle();
        logic        acc;
        logic        drn;
        logic [31:0] r;
        logic        e;
        exp_t        ent;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) void'(q.pop_front());
        if (acc) begin
            ref_enc(in_op, in_base, in_imm, r, e);
            if (e) begin
                if (m_err < MAXC) m_err++;
            end else begin
                if (m_ok < MAXC) m_ok++;
            end
            if (!(DROP && e)) begin
                ent.inst = r;
                ent.err  = e;
                q.push_back(ent);
            end
        end
        @(posedge cpu_clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_err", 32'(out_err), 32'(q[0].err));
        end
        chk("cnt_ok", 32'(cnt_ok), 32'(m_ok));
        chk("cnt_err", 32'(cnt_err), 32'(m_err));
        @(negedge cpu_clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 3'd0;
        in_base  = 32'd0;
        in_imm   = 32'd0;
    endtask

    // Single request into an empty pipe with a ready consumer, checked against a hand-derived word.
    task automatic directed(input string name, input logic [2:0] op, input logic [31:0] base,
                            input logic [31:0] imm, input logic [31:0] exp_inst, input logic exp_err);
        in_valid  = 1'b1;
        in_op     = op;
        in_base   = base;
        in_imm    = imm;
        out_ready = 1'b1;
        cycle();
        idle();
        if (DROP && exp_err) begin
            chk({name, "_dropped"}, 32'(out_valid), 32'd0);
        end else begin
            chk({name, "_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_inst"}, out_inst, exp_inst);
            chk({name, "_err"}, 32'(out_err), 32'(exp_err));
        end
        cycle();
    endtask

    task automatic do_reset();
        #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
        chk("rst_cnt_err", 32'(cnt_err), 32'd0);
        q.delete();
        m_ok  = 0;
        m_err = 0;
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        idle();
        cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ok  = 0;
        m_err = 0;
        cpu_rst_n = 1'b0;
        out_ready = 1'b0;
        idle();
        repeat (2) @(negedge cpu_clk);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_inst", out_inst, 32'd0);
        chk("init_out_err", 32'(out_err), 32'd0);
        chk("init_cnt_ok", 32'(cnt_ok), 32'd0);
        cpu_rst_n = 1'b1;
        cycle();

        directed("i_neg1", OP_I, 32'h00000013, 32'hFFFFFFFF, 32'hFFF00013, 1'b0);
        directed("i_over", OP_I, 32'h00000013, 32'h00000800, 32'h80000013, 1'b1);
        chk("i_over_cnt_err", 32'(cnt_err), 32'd1);
        directed("s_8", OP_S, 32'h00002023, 32'h00000008, 32'h00002423, 1'b0);
        directed("b_neg4", OP_B, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        directed("b_odd", OP_B, 32'h00000063, 32'h00000003, 32'h00000163, 1'b1);
        directed("u_ok", OP_U, 32'h00000037, 32'h12345000, 32'h12345037, 1'b0);
        directed("u_low", OP_U, 32'h00000037, 32'h12345001, 32'h12345037, 1'b1);
        directed("j_800", OP_J, 32'h0000006F, 32'h00000800, 32'h0010006F, 1'b0);
        directed("mv_31", OP_MV, 32'h0000000B, 32'h0000001F, 32'h01F0000B, 1'b0);
        directed("r_nz", OP_R, 32'h00B50533, 32'h00000001, 32'h00B50533, 1'b1);
        directed("bad_op", OP_BAD, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b1);

        // Saturation: five good requests on a 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) directed("sat", OP_I, 32'h00000013, 32'(i), 32'(i << 20) | 32'h13, 1'b0);
        chk("sat_cnt_ok", 32'(cnt_ok), 32'd3);

        // Backpressure: three back-to-back requests against a stalled consumer.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = OP_I;
            in_base  = 32'h00000093;
            in_imm   = 32'(i + 1);
            cycle();
            if (i == 1) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        chk("bp_accepted", 32'(cnt_ok), 32'd2);
        chk("bp_head", out_inst, 32'h00100093);
        idle();
        repeat (2) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with both entries occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_op    = OP_U;
            in_base  = 32'h00000017;
            in_imm   = 32'(i + 1) << 12;
            cycle();
        end
        idle();
        chk("full_before_rst", 32'(in_ready), 32'd0);
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Randomized stream with random backpressure.
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_base   = $urandom;
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2:       in_imm = $urandom & 32'hFFFFF000;
                default: in_imm = 32'($urandom_range(0, 31));
            endcase
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Streaming immediate encoder: the inverse of the core's immediate-extraction path. It takes a template instruction word, a 32-bit immediate value and a `SEXT_*` format code from defines.vh, and produces the instruction word with the immediate scattered into the RISC-V bit positions.
- Consumers are the self-test instruction generator and the instruction-ROM writer.
- Valid/ready on both sides, 1-cycle latency, 2-entry skid buffering, range checking, saturating statistics.

Parameters:
- CNT_W, 16, width of the accepted-ok and accepted-error statistic counters.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_op  in  3  format code (`SEXT_R/I/MOVE/S/B/U/J`).
- in_base  in  32  template word (opcode/rd/rs1/rs2/funct fields); immediate bit positions are overwritten.
- in_imm  in  32  immediate value, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_inst  out  32  encoded instruction.
- out_err  out  1  immediate not representable, or bad op.
- cnt_ok  out  CNT_W  accepted requests without error.
- cnt_err  out  CNT_W  accepted requests with error.

Behaviour:
- Reset (async assert, synchronous deassert to cpu_clk):
  - out_valid=0, out_inst=0, out_err=0.
  - Both buffer entries empty; cnt_ok=cnt_err=0.
  - in_ready=1 from the first clock edge after deassert.
  - Reset mid-transfer discards all buffered data; no partial output.
- Encoding: result=in_base except the listed fields.
  - R: no change; err if imm!=0.
  - I: [31:20]=imm[11:0]; err unless imm[31:11] all equal.
  - MOVE: [24:20]=imm[4:0]; err unless imm[31:5]==0.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; err unless imm[31:11] all equal.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; err if imm[0]=1 or imm[31:12] not all equal.
  - U: [31:12]=imm[31:12]; err if imm[11:0]!=0.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm[0]=1 or imm[31:20] not all equal.
  - Undefined op code: result=in_base, err=1.
  - On err the encoded bits are still the truncated fields above; no other corruption.
- Pipeline and handshake:
  - Encode is combinational on the input; the result is registered into the output entry.
  - Latency: accept at edge N, out_valid=1 after edge N (visible in cycle N+1) when the output entry was empty.
  - in_ready is registered and equals "skid entry empty"; it never depends combinationally on out_ready.
  - Accept while the output entry is full and not draining: the result goes to the skid entry and in_ready drops next cycle.
  - Output drain (out_valid&&out_ready) with the skid entry full: the skid entry moves to the output entry in the same edge and in_ready rises next cycle.
  - Simultaneous accept and drain with the skid entry empty: the new result replaces the output entry; no bubble.
  - Order is strictly preserved.
  - out_inst/out_err are stable while out_valid&&!out_ready.
- Counters:
  - Increment on the accept edge: cnt_ok if err=0, else cnt_err.
  - Saturate at 2^CNT_W-1; no wrap.

Optional Feature:
- IMM_PACK_DROP_ERR_EN defined:
  - Error requests are still accepted and counted in cnt_err, but never enter the buffer or appear on the output.
  - out_err is tied 0.
- Not defined:
  - Error requests are emitted normally with out_err=1.

Test Plan:
- I: base 0x00000013, imm 0xFFFFFFFF -> out_inst 0xFFF00013, err 0, one cycle after accept; imm 0x00000800 -> err 1, cnt_err=1.
- S/B: base 0x00002023, imm 8 -> 0x00002423. base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3. imm 0x00000003 on B -> err 1.
- U/J: base 0x00000037, imm 0x12345000 -> 0x12345037; imm 0x12345001 -> err 1. base 0x0000006F, imm 0x00000800 -> 0x0010006F.
- Backpressure:
  - out_ready=0, push 3 back-to-back requests -> only 2 accepted, in_ready=0 from the cycle after the second accept.
  - Release out_ready -> outputs appear in order, outputs held stable while stalled, no loss/duplication.
- Saturation/reset:
  - CNT_W=2: 5 good requests -> cnt_ok=3.
  - Assert cpu_rst_n low with both buffer entries full -> out_valid=0 and counters=0 immediately; in_ready=1 after release.
- With IMM_PACK_DROP_ERR_EN: stream ok/err/ok -> exactly two outputs, cnt_err=1, out_err never 1.
